osd_menu_ctrl: RTL and testbench

Parametrised OSD menu controller: turns infrared key strobes into a navigable N-item settings menu with per-item values. Edits land in a shadow bank; the live configuration updates only on a frame boundary. The menu hides itself after a programmable number of idle frames. It sits between the infrared receiver and the overlay/pattern generators, and drives both the menu renderer (`menu_on`, `sel_line`, shadow values) and the datapath mode controls (committed values).

---
 rtl/osd_pkg.sv | 27 ++
 rtl/osd_key_decoder.sv | 42 ++++
 rtl/osd_menu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_osd_menu_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared types for the OSD menu controller: FSM state encoding, decoded key
// bundle and the default infrared key codes.
package osd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NAV  = 2'd1,
    ST_EDIT = 2'd2
  } osd_state_e;

  typedef struct packed {
    logic menu;
    logic up;
    logic down;
    logic left;
    logic right;
    logic ok;
  } osd_keys_t;

  localparam logic [7:0] KEY_MENU_DEF  = 8'h45;
  localparam logic [7:0] KEY_UP_DEF    = 8'h18;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h52;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h08;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h5A;
  localparam logic [7:0] KEY_OK_DEF    = 8'h1C;

endpackage

// File: rtl/osd_key_decoder.sv
// Rising-edge detect on the key strobe plus code match. Decode is combinational
// from the edge so the controller's registered response lands one cycle later.
module osd_key_decoder
  import osd_pkg::*;
#(
  parameter logic [7:0] KEY_MENU  = KEY_MENU_DEF,
  parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_OK    = KEY_OK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] order,
  input  logic       order_en,
  output osd_keys_t  keys,
  output logic       key_any
);

  logic en_q;
  logic en_d;
  logic key_edge;

  always_comb begin
    en_d       = order_en;
    key_edge   = order_en & ~en_q;
    keys.menu  = key_edge & (order == KEY_MENU);
    keys.up    = key_edge & (order == KEY_UP);
    keys.down  = key_edge & (order == KEY_DOWN);
    keys.left  = key_edge & (order == KEY_LEFT);
    keys.right = key_edge & (order == KEY_RIGHT);
    keys.ok    = key_edge & (order == KEY_OK);
    key_any    = |keys;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= en_d;
  end

endmodule

// File: rtl/osd_menu_ctrl.sv
// OSD menu controller: key-driven navigation/edit FSM, shadow value bank,
// frame-aligned commit to the live configuration and idle-frame auto-hide.
module osd_menu_ctrl
  import osd_pkg::*;
#(
  parameter int                         N_ITEMS        = 5,
  parameter int                         VAL_W          = 4,
  parameter int                         MAX_VAL        = 2**VAL_W - 1,
  parameter logic [N_ITEMS*VAL_W-1:0]   DEFAULTS       = '0,
  parameter int                         TIMEOUT_FRAMES = 300,
  parameter logic [7:0]                 KEY_MENU       = KEY_MENU_DEF,
  parameter logic [7:0]                 KEY_UP         = KEY_UP_DEF,
  parameter logic [7:0]                 KEY_DOWN       = KEY_DOWN_DEF,
  parameter logic [7:0]                 KEY_LEFT       = KEY_LEFT_DEF,
  parameter logic [7:0]                 KEY_RIGHT      = KEY_RIGHT_DEF,
  parameter logic [7:0]                 KEY_OK         = KEY_OK_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    order,
  input  logic                          order_en,
  input  logic                          frame_1st_pxl,
  output logic                          menu_on,
  output logic                          editing,
  output logic [$clog2(N_ITEMS)-1:0]    sel_line,
  output logic [N_ITEMS*VAL_W-1:0]      item_val,
  output logic [N_ITEMS*VAL_W-1:0]      cfg_val,
  output logic                          cfg_update
);

  localparam int SEL_W = $clog2(N_ITEMS);
  localparam int BANK_W = N_ITEMS * VAL_W;
  localparam int CNT_W = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_ITEMS - 1);
  localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_V     = CNT_W'(TIMEOUT_FRAMES);

  osd_keys_t keys;
  logic      key_any;

  osd_key_decoder #(
    .KEY_MENU (KEY_MENU),
    .KEY_UP   (KEY_UP),
    .KEY_DOWN (KEY_DOWN),
    .KEY_LEFT (KEY_LEFT),
    .KEY_RIGHT(KEY_RIGHT),
    .KEY_OK   (KEY_OK)
  ) u_key_dec (
    .clk     (clk),
    .rst     (rst),
    .order   (order),
    .order_en(order_en),
    .keys    (keys),
    .key_any (key_any)
  );

  osd_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [BANK_W-1:0] item_q, item_d;
  logic [BANK_W-1:0] cfg_q, cfg_d;
  logic              upd_q, upd_d;
  logic              dirty_q, dirty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              menu_on_q, menu_on_d;
  logic              editing_q, editing_d;

  logic [VAL_W-1:0]  cur_val;
  logic [CNT_W-1:0]  cnt_inc;
  logic              changed;
  int unsigned       base;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    item_d  = item_q;
    cfg_d   = cfg_q;
    upd_d   = 1'b0;
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    changed = 1'b0;
    base    = int'(sel_q) * VAL_W;
    cur_val = item_q[base +: VAL_W];
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Commit samples the pre-key shadow bank; a same-cycle edit re-arms dirty below.
    if (frame_1st_pxl && dirty_q) begin
      cfg_d   = item_q;
      upd_d   = 1'b1;
      dirty_d = 1'b0;
    end

    if (key_any) begin
      cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (frame_1st_pxl) begin
      cnt_d = cnt_inc;
      if (TIMEOUT_FRAMES != 0 && cnt_inc >= TO_V) state_d = ST_IDLE;
    end

    case (state_q)
      ST_IDLE: begin
        if (keys.menu) state_d = ST_NAV;
      end
      ST_NAV: begin
        if (keys.menu)       state_d = ST_IDLE;
        else if (keys.up)    sel_d = (sel_q == '0) ? LAST_SEL : sel_q - 1'b1;
        else if (keys.down)  sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        else if (keys.ok)    state_d = ST_EDIT;
      end
      ST_EDIT: begin
        if (keys.ok || keys.menu) begin
          state_d = ST_NAV;
        end else if (keys.left && cur_val != '0) begin
          item_d[base +: VAL_W] = cur_val - 1'b1;
          changed = 1'b1;
        end else if (keys.right && cur_val < MAX_V) begin
          item_d[base +: VAL_W] = cur_val + 1'b1;
          changed = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (changed) dirty_d = 1'b1;

    menu_on_d = (state_d != ST_IDLE);
    editing_d = (state_d == ST_EDIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      item_q    <= DEFAULTS;
      cfg_q     <= DEFAULTS;
      upd_q     <= 1'b0;
      dirty_q   <= 1'b0;
      cnt_q     <= '0;
      menu_on_q <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      item_q    <= item_d;
      cfg_q     <= cfg_d;
      upd_q     <= upd_d;
      dirty_q   <= dirty_d;
      cnt_q     <= cnt_d;
      menu_on_q <= menu_on_d;
      editing_q <= editing_d;
    end
  end

  assign menu_on    = menu_on_q;
  assign editing    = editing_q;
  assign sel_line   = sel_q;
  assign item_val   = item_q;
  assign cfg_val    = cfg_q;
  assign cfg_update = upd_q;

endmodule

// File: tb/tb_osd_menu_ctrl.sv
// Scoreboard bench for osd_menu_ctrl: directed menu walk plus random key/frame
// traffic, checked every cycle against a behavioural menu model.
module tb_osd_menu_ctrl;

  localparam int          N    = 5;
  localparam int          W    = 4;
  localparam int          MAXV = 15;
  localparam int          TO   = 3;
  localparam logic [19:0] DEF  = 20'h21043;

  localparam logic [7:0] K_M = 8'h45;
  localparam logic [7:0] K_U = 8'h18;
  localparam logic [7:0] K_D = 8'h52;
  localparam logic [7:0] K_L = 8'h08;
  localparam logic [7:0] K_R = 8'h5A;
  localparam logic [7:0] K_O = 8'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  order = 8'h00;
  logic        order_en = 1'b0;
  logic        frame_1st_pxl = 1'b0;
  logic        menu_on, editing, cfg_update;
  logic [2:0]  sel_line;
  logic [19:0] item_val, cfg_val;

  osd_menu_ctrl #(
    .N_ITEMS(N), .VAL_W(W), .MAX_VAL(MAXV), .DEFAULTS(DEF), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst(rst), .order(order), .order_en(order_en),
    .frame_1st_pxl(frame_1st_pxl), .menu_on(menu_on), .editing(editing),
    .sel_line(sel_line), .item_val(item_val), .cfg_val(cfg_val),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          menu_on;
    bit          editing;
    int          sel;
    logic [19:0] item;
    logic [19:0] cfg;
    bit          upd;
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] commit_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  // Reference model: mode 0 hidden, 1 browsing, 2 editing the selected line.
  int m_mode, m_sel, m_cnt;
  int m_val[N];
  int m_cfg[N];
  bit m_dirty, m_prev_en;

  function automatic logic [19:0] pack_vals(input int v[N]);
    logic [19:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = v[i][3:0];
    return p;
  endfunction

  function automatic exp_t snapshot(input bit upd);
    exp_t e;
    e.menu_on = (m_mode != 0);
    e.editing = (m_mode == 2);
    e.sel     = m_sel;
    e.item    = pack_vals(m_val);
    e.cfg     = pack_vals(m_cfg);
    e.upd     = upd;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_cnt = 0; m_dirty = 0; m_prev_en = 0;
    for (int i = 0; i < N; i++) begin
      m_val[i] = int'(DEF[i*W +: W]);
      m_cfg[i] = m_val[i];
    end
  endtask

  task automatic model_step(input bit en, input logic [7:0] code, input bit fr, output exp_t e);
    bit ev, known, upd;
    int old;
    ev = en && !m_prev_en;
    m_prev_en = en;
    known = ev && (code == K_M || code == K_U || code == K_D ||
                   code == K_L || code == K_R || code == K_O);
    upd = 0;
    old = m_mode;
    if (fr && m_dirty) begin
      m_cfg = m_val;
      m_dirty = 0;
      upd = 1;
      commit_q.push_back(pack_vals(m_cfg));
    end
    if (known || old == 0) m_cnt = 0;
    else if (fr) begin
      if (m_cnt < TO) m_cnt++;
      if (m_cnt >= TO) m_mode = 0;
    end
    if (known) begin
      if (old == 0) begin
        if (code == K_M) m_mode = 1;
      end else if (old == 1) begin
        if (code == K_M) m_mode = 0;
        else if (code == K_U) m_sel = (m_sel + N - 1) % N;
        else if (code == K_D) m_sel = (m_sel + 1) % N;
        else if (code == K_O) m_mode = 2;
      end else begin
        if (code == K_O || code == K_M) m_mode = 1;
        else if (code == K_L && m_val[m_sel] > 0) begin
          m_val[m_sel]--; m_dirty = 1;
        end else if (code == K_R && m_val[m_sel] < MAXV) begin
          m_val[m_sel]++; m_dirty = 1;
        end
      end
    end
    e = snapshot(upd);
  endtask

  task automatic step(input bit r, input bit en, input logic [7:0] code, input bit fr);
    exp_t e;
    @(negedge clk);
    rst = r; order_en = en; order = code; frame_1st_pxl = fr;
    if (r) begin
      model_reset();
      e = snapshot(0);
    end else begin
      model_step(en, code, fr, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [7:0] code);
    step(0, 1, code, 0);
    step(0, 0, code, 0);
  endtask

  task automatic frame_tick();
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
  endtask

  always @(posedge clk) begin
    exp_t        e;
    logic [19:0] c;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (menu_on !== e.menu_on || editing !== e.editing || sel_line !== 3'(e.sel) ||
          item_val !== e.item || cfg_val !== e.cfg || cfg_update !== e.upd) begin
        n_fail++;
        $display("FAIL cycle_state t=%0t: got menu_on=%0b editing=%0b sel=%0d item=%h cfg=%h upd=%0b, want menu_on=%0b editing=%0b sel=%0d item=%h cfg=%h upd=%0b",
                 $time, menu_on, editing, sel_line, item_val, cfg_val, cfg_update,
                 e.menu_on, e.editing, e.sel, e.item, e.cfg, e.upd);
      end
    end
    if (cfg_update === 1'b1) begin
      n_cmp++;
      if (commit_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected t=%0t: got cfg_update with cfg=%h, want no commit", $time, cfg_val);
      end else begin
        c = commit_q.pop_front();
        if (cfg_val !== c) begin
          n_fail++;
          $display("FAIL commit_value t=%0t: got cfg=%h, want %h", $time, cfg_val, c);
        end
      end
    end
  end

  logic [7:0] key_tab [6];

  initial begin
    key_tab[0] = K_M; key_tab[1] = K_U; key_tab[2] = K_D;
    key_tab[3] = K_L; key_tab[4] = K_R; key_tab[5] = K_O;
    model_reset();

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Hidden menu ignores editing keys.
    press(K_R);
    frame_tick();

    // Navigation wrap and a long-held strobe.
    press(K_M);
    press(K_U);
    press(K_D);
    press(K_D);
    for (int i = 0; i < 50; i++) step(0, 1, K_D, 0);
    step(0, 0, K_D, 0);
    press(K_U);

    // Edit line 1: saturate low, then high.
    press(K_O);
    press(K_L);
    for (int i = 0; i < 5; i++) press(K_L);
    frame_tick();
    for (int i = 0; i < 17; i++) press(K_R);
    frame_tick();
    frame_tick();

    // Line 2: frame-aligned commit, then edit coinciding with a frame.
    press(K_O);
    press(K_D);
    press(K_O);
    press(K_R);
    press(K_R);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0);
    frame_tick();
    step(0, 1, K_R, 1);
    step(0, 0, K_R, 0);
    frame_tick();
    frame_tick();

    // Auto-hide with a key restarting the count; unknown code does not.
    press(K_O);
    frame_tick();
    frame_tick();
    press(K_U);
    frame_tick();
    press(8'h77);
    frame_tick();
    frame_tick();
    frame_tick();

    // Reset mid-edit drops uncommitted shadow edits.
    press(K_M);
    press(K_O);
    press(K_R);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    for (int i = 0; i < 4000; i++) begin
      bit          r, en, fr;
      logic [7:0]  code;
      r    = ($urandom_range(0, 599) == 0);
      en   = ($urandom_range(0, 2) == 0);
      code = ($urandom_range(0, 7) < 6) ? key_tab[$urandom_range(0, 5)] : 8'($urandom);
      fr   = ($urandom_range(0, 11) == 0);
      step(r, en, code, fr);
    end

    step(0, 0, 8'h00, 0);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0 || commit_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d states and %0d commits outstanding, want 0 and 0",
               exp_q.size(), commit_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
